// File: rtl/cpu_isa_pkg.sv
// Shared CPU instruction-set definitions: instruction word layout,
// field positions and the program loader state encoding.
package cpu_isa_pkg;

    localparam int INSTR_W = 16;
    localparam int FIELD_W = 4;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int DR_MSB  = 11;
    localparam int DR_LSB  = 8;
    localparam int SA_MSB  = 7;
    localparam int SA_LSB  = 4;
    localparam int SB_MSB  = 3;
    localparam int SB_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

    // Builds an instruction word that the instruction register splits back
    // into exactly the same opcode/DR/SA/SB fields.
    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [FIELD_W-1:0] opc,
        input logic [FIELD_W-1:0] dr,
        input logic [FIELD_W-1:0] sa,
        input logic [FIELD_W-1:0] sb
    );
        logic [INSTR_W-1:0] word;
        word                  = '0;
        word[OPC_MSB:OPC_LSB] = opc;
        word[DR_MSB:DR_LSB]   = dr;
        word[SA_MSB:SA_LSB]   = sa;
        word[SB_MSB:SB_LSB]   = sb;
        return word;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO that decouples accepted field sets from the
// instruction memory write port. Pointers carry one extra wrap bit so
// full and empty can be told apart without a separate occupancy counter.
module instr_fifo
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               pop,
    output logic [INSTR_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [INSTR_W-1:0] store [DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rdata = store[rd_ptr[PTR_W-1:0]];

    // Storage needs no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            store[wr_ptr[PTR_W-1:0]] <= wdata;
        end
    end

    // Pointer update; reset discards any buffered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Program loader: packs decoded instruction fields into 16-bit words and
// writes them to consecutive instruction memory addresses starting at a
// latched base address. Words are buffered in a small FIFO so the memory
// write side is registered while the input stream runs at full rate.
module instr_loader
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [3:0]         in_dr,
    input  logic [3:0]         in_sa,
    input  logic [3:0]         in_sb,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    loader_state_t      state_q;
    loader_state_t      state_d;
    logic [ADDR_W-1:0]  count_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [ADDR_W:0]    accepted_q;
    logic [ADDR_W:0]    written_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [INSTR_W-1:0] mem_wdata_q;
    logic               overflow_q;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] fifo_rdata;
    logic               start_ok;

    assign push      = in_valid && in_ready;
    assign start_ok  = (state_q == ST_IDLE) && start;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign overflow  = overflow_q;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (pack_instr(in_opcode, in_dr, in_sa, in_sb)),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and handshake decode; LOAD leaves only once the final
    // write is already on the memory port, so done follows it by a cycle.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy     = 1'b1;
                in_ready = !fifo_full && (accepted_q < {1'b0, count_q});
                pop      = !fifo_empty;
                if (written_q == {1'b0, count_q}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load bookkeeping and the registered memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_addr_q   <= '0;
            accepted_q  <= '0;
            written_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            mem_we_q <= pop;
            if (start_ok) begin
                count_q    <= count;
                wr_addr_q  <= base_addr;
                accepted_q <= '0;
                written_q  <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) begin
                    accepted_q <= accepted_q + CNT_ONE;
                end
                if (pop) begin
                    mem_addr_q  <= wr_addr_q;
                    mem_wdata_q <= fifo_rdata;
                    wr_addr_q   <= wr_addr_q + ADDR_ONE;
                    written_q   <= written_q + CNT_ONE;
                    if ((wr_addr_q == '1) &&
                        ((written_q + CNT_ONE) < {1'b0, count_q})) begin
                        overflow_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
